// File: rtl/game_timer_ctrl.sv
// Pacing and sequencing controller for the 2-digit BCD game timer.
// Optional build macro: GAME_TIMER_WARN_BLINK_EN (blinks the low-time warning at the game-second rate).
module game_timer_ctrl #(
  parameter int         TICK_DIV    = 25_000_000,
  parameter logic [3:0] LIMIT_H     = 4'h9,
  parameter logic [3:0] LIMIT_L     = 4'h9,
  parameter logic [7:0] WARN_THRESH = 8'h05
) (
  input  logic       i_clk,
  input  logic       i_resetN,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_abort,
  input  logic       i_count_down_mode,
  input  logic [3:0] i_countL,
  input  logic [3:0] i_countH,
  input  logic       i_tc,
  output logic       o_loadN,
  output logic       o_ena,
  output logic       o_ena_cnt,
  output logic       o_countDownMode,
  output logic       o_running,
  output logic       o_time_up,
  output logic       o_expired,
  output logic       o_warn
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] RUNNING = 3'd2;
  localparam logic [2:0] PAUSED  = 3'd3;
  localparam logic [2:0] EXPIRED = 3'd4;

  logic [2:0]    r_state;
  logic [PW-1:0] r_presc;
  logic          r_cdm;
  logic          r_timeUp;

  logic w_done;
  logic w_isRunning;
  logic w_isPaused;
  logic w_warnCond;

  assign w_isRunning = (r_state == RUNNING);
  assign w_isPaused  = (r_state == PAUSED);

  // Expiry depends on direction: terminal count going down, the BCD limit going up.
  assign w_done = r_cdm ? i_tc : ({i_countH, i_countL} == {LIMIT_H, LIMIT_L});

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_state  <= IDLE;
      r_presc  <= '0;
      r_cdm    <= 1'b1;
      r_timeUp <= 1'b0;
    end else begin
      r_timeUp <= 1'b0;
      if (i_abort) begin
        r_state <= IDLE;
      end else if (i_start) begin
        r_state <= LOAD;
        r_cdm   <= i_count_down_mode;
      end else begin
        case (r_state)
          LOAD: begin
            r_state <= RUNNING;
            r_presc <= '0;
          end
          RUNNING: begin
            r_presc <= (r_presc == PMAX) ? '0 : r_presc + PW'(1);
            if (i_pause) begin
              r_state <= PAUSED;
            end else if (w_done) begin
              r_state  <= EXPIRED;
              r_timeUp <= 1'b1;
            end
          end
          PAUSED: begin
            if (!i_pause) r_state <= RUNNING;
          end
          IDLE, EXPIRED: begin
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // A tick coinciding with expiry is suppressed so the timer never steps past 00 or the limit.
  assign o_ena_cnt       = w_isRunning && (r_presc == PMAX) && !w_done;
  assign o_loadN         = (r_state != LOAD);
  assign o_ena           = (r_state == LOAD) || w_isRunning || w_isPaused;
  assign o_countDownMode = r_cdm;
  assign o_running       = w_isRunning;
  assign o_time_up       = r_timeUp;
  assign o_expired       = (r_state == EXPIRED);

  assign w_warnCond = r_cdm && (w_isRunning || w_isPaused) &&
                      ({i_countH, i_countL} <= WARN_THRESH) && !i_tc;

`ifdef GAME_TIMER_WARN_BLINK_EN
  assign o_warn = w_warnCond && (r_presc < HALF);
`else
  assign o_warn = w_warnCond;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with a behavioural BCD timer model on its feedback path.
module tb_game_timer_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       resetN;
  logic       start;
  logic       pause;
  logic       abort;
  logic       cdmIn;
  logic [3:0] cntL = 4'h0;
  logic [3:0] cntH = 4'h0;
  logic       tc;
  logic       loadN;
  logic       ena;
  logic       enaCnt;
  logic       cdmOut;
  logic       running;
  logic       timeUp;
  logic       expired;
  logic       warn;
  logic [7:0] preset;
  int         nVectors = 0;
  int         nMiscompares = 0;
  int         pulses;
  logic       warnExp;

  always #5 clk = ~clk;

  game_timer_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .LIMIT_H    (4'h9),
    .LIMIT_L    (4'h9),
    .WARN_THRESH(8'h05)
  ) dut (
    .i_clk            (clk),
    .i_resetN         (resetN),
    .i_start          (start),
    .i_pause          (pause),
    .i_abort          (abort),
    .i_count_down_mode(cdmIn),
    .i_countL         (cntL),
    .i_countH         (cntH),
    .i_tc             (tc),
    .o_loadN          (loadN),
    .o_ena            (ena),
    .o_ena_cnt        (enaCnt),
    .o_countDownMode  (cdmOut),
    .o_running        (running),
    .o_time_up        (timeUp),
    .o_expired        (expired),
    .o_warn           (warn)
  );

  // Downstream 2-digit BCD up/down timer
  assign tc = ({cntH, cntL} == 8'h00);
  always @(posedge clk) begin
    if (!loadN) begin
      {cntH, cntL} <= preset;
    end else if (ena && enaCnt) begin
      if (cdmOut) begin
        if (cntL == 4'h0) begin cntL <= 4'h9; cntH <= cntH - 4'h1; end
        else cntL <= cntL - 4'h1;
      end else begin
        if (cntL == 4'h9) begin cntL <= 4'h0; cntH <= cntH + 4'h1; end
        else cntL <= cntL + 4'h1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic p, input logic m);
    start = s;
    abort = a;
    pause = p;
    cdmIn = m;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetN = 1'b0;
    preset = 8'h12;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(2);
    checkBit("rst_loadN", loadN, 1'b1);
    checkBit("rst_ena", ena, 1'b0);
    checkBit("rst_ena_cnt", enaCnt, 1'b0);
    checkBit("rst_cdm", cdmOut, 1'b1);
    checkBit("rst_running", running, 1'b0);
    checkBit("rst_time_up", timeUp, 1'b0);
    checkBit("rst_expired", expired, 1'b0);
    checkBit("rst_warn", warn, 1'b0);

    // Countdown from 12: ticks on every 4th RUNNING cycle, warning from 05 down to 01
    resetN = 1'b1;
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkBit("cd_load_low", loadN, 1'b0);
    checkBit("cd_load_ena", ena, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkBit("cd_load_one_cycle", loadN, 1'b1);
    pulses = 0;
    for (int k = 1; k <= 56; k++) begin
      if (enaCnt === 1'b1) pulses++;
      warnExp = (k >= 29) && (k <= 48);
`ifdef GAME_TIMER_WARN_BLINK_EN
      warnExp = warnExp && (((k - 1) % 4) < 2);
`endif
      checkBit("cd_ena_cnt", enaCnt, (k % 4 == 0) && (k <= 48));
      checkBit("cd_running", running, k <= 49);
      checkBit("cd_time_up", timeUp, k == 50);
      checkBit("cd_expired", expired, k >= 50);
      checkBit("cd_warn", warn, warnExp);
      tick(1);
    end
    checkByte("cd_pulses", 8'(pulses), 8'd12);
    checkByte("cd_hold_00", {cntH, cntL}, 8'h00);
    checkBit("cd_exp_ena", ena, 1'b0);

    // Reset in the middle of an up-count run
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkBit("mr_running", running, 1'b1);
    checkBit("mr_cdm_latched", cdmOut, 1'b0);
    tick(2);
    resetN = 1'b0;
    tick(2);
    checkBit("mr_loadN", loadN, 1'b1);
    checkBit("mr_ena", ena, 1'b0);
    checkBit("mr_running0", running, 1'b0);
    checkBit("mr_cdm", cdmOut, 1'b1);
    checkBit("mr_expired", expired, 1'b0);
    checkBit("mr_warn", warn, 1'b0);
    resetN = 1'b1;
    tick(1);
    checkBit("mr_rel_ena_cnt", enaCnt, 1'b0);
    checkBit("mr_rel_running", running, 1'b0);
    checkBit("mr_rel_loadN", loadN, 1'b1);

    // Pause one cycle after a tick, hold, then resume
    preset = 8'h12;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(4);
    checkBit("pa_first_tick", enaCnt, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkBit("pa_running", running, 1'b0);
      checkBit("pa_ena_cnt", enaCnt, 1'b0);
      checkBit("pa_ena", ena, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkBit("pa_resume", running, 1'b1);
    checkBit("pa_resume_c1", enaCnt, 1'b0);
    tick(1);
    checkBit("pa_resume_c2", enaCnt, 1'b0);
    tick(1);
    checkBit("pa_resume_c3", enaCnt, 1'b1);
    checkByte("pa_count", {cntH, cntL}, 8'h11);

    // start together with abort: abort wins
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick(1);
    checkBit("pr_abort_loadN", loadN, 1'b1);
    checkBit("pr_abort_running", running, 1'b0);
    checkBit("pr_abort_ena", ena, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkBit("pr_abort_loadN2", loadN, 1'b1);

    // Restart during RUNNING restarts the prescaler
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkBit("pr_restart_load", loadN, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkBit("pr_restart_c1", enaCnt, 1'b0);
    tick(2);
    checkBit("pr_restart_c3", enaCnt, 1'b0);
    tick(1);
    checkBit("pr_restart_c4", enaCnt, 1'b1);

    // Count up from 97 to the 99 limit
    preset = 8'h97;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      if (enaCnt === 1'b1) pulses++;
      checkBit("up_ena_cnt", enaCnt, (k == 4) || (k == 8));
      checkBit("up_time_up", timeUp, k == 10);
      checkBit("up_expired", expired, k >= 10);
      checkBit("up_warn", warn, 1'b0);
      tick(1);
    end
    checkByte("up_pulses", 8'(pulses), 8'd2);
    checkByte("up_hold_99", {cntH, cntL}, 8'h99);
    checkBit("up_cdm", cdmOut, 1'b0);

    // Load value already 00: expiry straight after LOAD, no tick
    preset = 8'h00;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkBit("z_running", running, 1'b1);
    checkBit("z_ena_cnt", enaCnt, 1'b0);
    checkBit("z_warn", warn, 1'b0);
    tick(1);
    checkBit("z_time_up", timeUp, 1'b1);
    checkBit("z_expired", expired, 1'b1);
    tick(1);
    checkBit("z_time_up_once", timeUp, 1'b0);
    checkBit("z_expired_hold", expired, 1'b1);

    // Abort out of EXPIRED
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkBit("ab_expired", expired, 1'b0);
    checkBit("ab_running", running, 1'b0);
    checkBit("ab_loadN", loadN, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
